// File: rtl/p_cache_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : p_cache_arbiter_if
// Purpose  : Bundles the I-cache miss port, the D-cache miss/writeback port and
//            the physical-memory (cacheline adaptor) port shared by both.
// Modports : slave  - the arbiter's view (cache requests and memory response
//                     in, cache responses and memory command out)
//            master - the surrounding caches plus memory, the mirror image
// Params   : ADDR_W - line address width, LINE_W - cacheline width
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface p_cache_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   // I-cache side
   logic              i_pmem_read;
   logic [ADDR_W-1:0] i_pmem_address;
   logic [LINE_W-1:0] i_pmem_rdata;
   logic              i_pmem_resp;
   // D-cache side
   logic              d_pmem_read;
   logic              d_pmem_write;
   logic [ADDR_W-1:0] d_pmem_address;
   logic [LINE_W-1:0] d_pmem_wdata;
   logic [LINE_W-1:0] d_pmem_rdata;
   logic              d_pmem_resp;
   // Physical-memory side
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  pmem_rdata, pmem_resp,
      output i_pmem_rdata, i_pmem_resp,
      output d_pmem_rdata, d_pmem_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output pmem_rdata, pmem_resp,
      input  i_pmem_rdata, i_pmem_resp,
      input  d_pmem_rdata, d_pmem_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/p_cache_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : p_cache_arbiter
// Purpose  : Shares one physical-memory port between the I-cache line-fill
//            path and the D-cache fill/writeback path. The winner's command
//            is latched at grant, held on the memory port until pmem_resp,
//            and the response pulse is routed back to that requester. Ties
//            are broken round-robin; a dead TURN cycle follows every
//            transaction so the served requester can drop its level.
// Ports    : clk          - clock, all state on rising edge
//            rst          - asynchronous active-low reset
//            bus          - p_cache_arbiter_if.slave (cache and memory ports)
//            busy         - high whenever the arbiter is not IDLE
//            protocol_err - sticky, D read and write seen together at grant
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module p_cache_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   p_cache_arbiter_if.slave  bus,
   output logic              busy,
   output logic              protocol_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE_I = 2'd1,
      ST_SERVE_D = 2'd2,
      ST_TURN    = 2'd3
   } state_t;

   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   state_t            state_q,        state_d;
   logic              last_grant_q,   last_grant_d;
   logic [ADDR_W-1:0] cmd_addr_q,     cmd_addr_d;
   logic [LINE_W-1:0] cmd_wdata_q,    cmd_wdata_d;
   logic              cmd_write_q,    cmd_write_d;
   logic              protocol_err_q, protocol_err_d;

   logic w_i_req;
   logic w_d_req;
   logic w_grant_i;
   logic w_grant_d;
   logic w_pmem_read;
   logic w_pmem_write;
   logic w_i_resp;
   logic w_d_resp;

   assign w_i_req = bus.i_pmem_read;
   assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;

   // Exactly one grant whenever any request is pending: a lone requester
   // always wins, and on a tie the side not granted last time wins.
   assign w_grant_i = w_i_req & (~w_d_req | (last_grant_q == GRANT_D));
   assign w_grant_d = w_d_req & (~w_i_req | (last_grant_q == GRANT_I));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         last_grant_q   <= GRANT_D;
         cmd_addr_q     <= '0;
         cmd_wdata_q    <= '0;
         cmd_write_q    <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         cmd_addr_q     <= cmd_addr_d;
         cmd_wdata_q    <= cmd_wdata_d;
         cmd_write_q    <= cmd_write_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      cmd_addr_d     = cmd_addr_q;
      cmd_wdata_d    = cmd_wdata_q;
      cmd_write_d    = cmd_write_q;
      protocol_err_d = protocol_err_q;
      w_pmem_read    = 1'b0;
      w_pmem_write   = 1'b0;
      w_i_resp       = 1'b0;
      w_d_resp       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_grant_i) begin
               state_d      = ST_SERVE_I;
               last_grant_d = GRANT_I;
               cmd_addr_d   = bus.i_pmem_address;
               cmd_wdata_d  = '0;
               cmd_write_d  = 1'b0;
            end else if (w_grant_d) begin
               state_d      = ST_SERVE_D;
               last_grant_d = GRANT_D;
               cmd_addr_d   = bus.d_pmem_address;
               cmd_wdata_d  = bus.d_pmem_wdata;
               // Write takes priority when the D-cache raises both levels;
               // the illegal combination is remembered until reset.
               cmd_write_d  = bus.d_pmem_write;
               if (bus.d_pmem_read && bus.d_pmem_write) begin
                  protocol_err_d = 1'b1;
               end
            end
         end

         ST_SERVE_I: begin
            w_pmem_read  = ~cmd_write_q;
            w_pmem_write = cmd_write_q;
            if (bus.pmem_resp) begin
               w_i_resp = 1'b1;
               state_d  = ST_TURN;
            end
         end

         ST_SERVE_D: begin
            w_pmem_read  = ~cmd_write_q;
            w_pmem_write = cmd_write_q;
            if (bus.pmem_resp) begin
               w_d_resp = 1'b1;
               state_d  = ST_TURN;
            end
         end

         ST_TURN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.pmem_read    = w_pmem_read;
   assign bus.pmem_write   = w_pmem_write;
   assign bus.pmem_address = cmd_addr_q;
   assign bus.pmem_wdata   = cmd_wdata_q;
   assign bus.i_pmem_resp  = w_i_resp;
   assign bus.d_pmem_resp  = w_d_resp;

   // Read data is a plain mirror; only the resp pulses qualify it.
   assign bus.i_pmem_rdata = bus.pmem_rdata;
   assign bus.d_pmem_rdata = bus.pmem_rdata;

   assign busy         = (state_q != ST_IDLE);
   assign protocol_err = protocol_err_q;

endmodule
`default_nettype wire

// File: tb/tb_p_cache_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_p_cache_arbiter
// Purpose  : Directed bench for p_cache_arbiter. Expected memory commands are
//            queued when a request is raised and compared when the arbiter
//            puts a command on the memory port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_p_cache_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;
   logic protocol_err;

   always #5 clk = ~clk;

   p_cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   p_cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .busy         (busy),
      .protocol_err (protocol_err)
   );

   typedef struct {
      logic              is_d;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic is_d, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] wdata);
      exp_t e;
      e.is_d  = is_d;
      e.wr    = wr;
      e.addr  = addr;
      e.wdata = wdata;
      sb.push_back(e);
   endtask

   // Waits (bounded) for a memory command, then checks it against the
   // oldest queued expectation and the number of negedges it took.
   task automatic wait_cmd(input int exp_wait);
      int n    = 0;
      bit seen = 1'b0;
      while (!seen && n < 50) begin
         @(negedge clk);
         n++;
         if (bus.pmem_read || bus.pmem_write) seen = 1'b1;
      end
      if (!seen) begin
         chk("cmd_timeout", 256'(seen), 256'(1));
         $display("%0d/%0d checks passed", n_pass, n_total);
         $fatal(1, "FAIL cmd_timeout: no memory command within 50 cycles");
      end
      chk("grant_latency", 256'(n), 256'(exp_wait));
      if (sb.size() == 0) begin
         chk("sb_underflow", 256'(sb.size()), 256'(1));
         $display("%0d/%0d checks passed", n_pass, n_total);
         $fatal(1, "FAIL sb_underflow: command with no expectation queued");
      end
      cur = sb.pop_front();
      chk("cmd_write", 256'(bus.pmem_write), 256'(cur.wr));
      chk("cmd_read",  256'(bus.pmem_read),  256'(!cur.wr));
      chk("cmd_addr",  256'(bus.pmem_address), 256'(cur.addr));
      chk("cmd_wdata", bus.pmem_wdata, cur.wdata);
      chk("cmd_busy",  256'(busy), 256'(1));
   endtask

   // Full transaction: command check, lat hold cycles, resp cycle, TURN.
   task automatic serve(input int exp_wait, input int lat, input bit perturb);
      logic [LINE_W-1:0] rd;
      wait_cmd(exp_wait);
      for (int k = 0; k < lat; k++) begin
         @(posedge clk); #1;
         if (perturb) begin
            if (cur.is_d) begin
               bus.d_pmem_address = $urandom;
               bus.d_pmem_wdata   = ~cur.wdata;
            end else begin
               bus.i_pmem_address = $urandom;
            end
         end
         @(negedge clk);
         chk("hold_write", 256'(bus.pmem_write), 256'(cur.wr));
         chk("hold_addr",  256'(bus.pmem_address), 256'(cur.addr));
         chk("hold_wdata", bus.pmem_wdata, cur.wdata);
         chk("hold_noresp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
      end
      @(posedge clk); #1;
      rd = {8{$urandom}};
      bus.pmem_rdata = rd;
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
      chk("i_resp", 256'(bus.i_pmem_resp), 256'(!cur.is_d));
      chk("d_resp", 256'(bus.d_pmem_resp), 256'(cur.is_d));
      chk("rdata", cur.is_d ? bus.d_pmem_rdata : bus.i_pmem_rdata, rd);
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      if (cur.is_d) begin
         bus.d_pmem_read  = 1'b0;
         bus.d_pmem_write = 1'b0;
      end else begin
         bus.i_pmem_read = 1'b0;
      end
      @(negedge clk);
      chk("turn_busy", 256'(busy), 256'(1));
      chk("turn_cmd",  256'({bus.pmem_read, bus.pmem_write}), 256'(0));
      chk("turn_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_pmem_read    = 1'b0;
      bus.i_pmem_address = '0;
      bus.d_pmem_read    = 1'b0;
      bus.d_pmem_write   = 1'b0;
      bus.d_pmem_address = '0;
      bus.d_pmem_wdata   = '0;
      bus.pmem_rdata     = '0;
      bus.pmem_resp      = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy",  256'(busy), 256'(0));
      chk("rst_cmd",   256'({bus.pmem_read, bus.pmem_write}), 256'(0));
      chk("rst_addr",  256'(bus.pmem_address), 256'(0));
      chk("rst_wdata", bus.pmem_wdata, 256'(0));
      chk("rst_err",   256'(protocol_err), 256'(0));
      chk("rst_resp",  256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      // I-only fill, memory answers 5 cycles after pmem_read rises
      @(posedge clk); #1;
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 32'h0000_0040;
      push(1'b0, 1'b0, 32'h0000_0040, '0);
      serve(2, 4, 1'b1);
      @(negedge clk);
      chk("i_busy_fall", 256'(busy), 256'(0));

      // D writeback, address perturbed during service
      @(posedge clk); #1;
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 32'h0000_1000;
      bus.d_pmem_wdata   = {8{32'hDEAD_BEEF}};
      push(1'b1, 1'b1, 32'h0000_1000, {8{32'hDEAD_BEEF}});
      serve(2, 3, 1'b1);
      @(negedge clk);
      chk("d_busy_fall", 256'(busy), 256'(0));

      // Fresh reset, then a tie: first tie goes to I
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 32'h0000_0100;
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_address = 32'h0000_0200;
      bus.d_pmem_wdata   = {8{32'h1234_5678}};
      push(1'b0, 1'b0, 32'h0000_0100, '0);
      push(1'b1, 1'b0, 32'h0000_0200, {8{32'h1234_5678}});
      serve(2, 0, 1'b0);
      // I re-requests while D is still held: this tie goes to D
      @(posedge clk); #1;
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 32'h0000_0300;
      push(1'b0, 1'b0, 32'h0000_0300, '0);
      serve(2, 1, 1'b0);
      serve(2, 1, 1'b0);

      // Read and write together: write issued, sticky error
      @(posedge clk); #1;
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 32'h0000_2000;
      bus.d_pmem_wdata   = {8{32'hA5A5_5A5A}};
      push(1'b1, 1'b1, 32'h0000_2000, {8{32'hA5A5_5A5A}});
      serve(2, 2, 1'b0);
      chk("err_set", 256'(protocol_err), 256'(1));
      @(posedge clk); #1;
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = 32'h0000_0080;
      push(1'b0, 1'b0, 32'h0000_0080, '0);
      serve(2, 1, 1'b0);
      chk("err_sticky", 256'(protocol_err), 256'(1));

      // Spurious pmem_resp in IDLE
      @(posedge clk); #1;
      bus.pmem_resp = 1'b1;
      @(negedge clk);
      chk("spur_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
      chk("spur_busy", 256'(busy), 256'(0));
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      @(negedge clk);
      chk("spur_busy_after", 256'(busy), 256'(0));
      chk("spur_cmd_after", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));

      // Reset asserted in the middle of a D write
      @(posedge clk); #1;
      bus.d_pmem_write   = 1'b1;
      bus.d_pmem_address = 32'h0000_3000;
      bus.d_pmem_wdata   = {8{32'h0F0F_F0F0}};
      push(1'b1, 1'b1, 32'h0000_3000, {8{32'h0F0F_F0F0}});
      wait_cmd(2);
      chk("err_before_rst", 256'(protocol_err), 256'(1));
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("arst_write", 256'(bus.pmem_write), 256'(0));
      chk("arst_busy",  256'(busy), 256'(0));
      chk("arst_err",   256'(protocol_err), 256'(0));
      chk("arst_addr",  256'(bus.pmem_address), 256'(0));
      chk("arst_resp",  256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
      bus.d_pmem_write = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 256'(busy), 256'(0));
      chk("sb_drained", 256'(sb.size()), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/p_cache_arbiter.md
# p_cache_arbiter

Shares the single physical-memory (cacheline-adaptor) port between the pipelined I-cache miss path and the D-cache miss/writeback path. Each requester drives a level-held read (or write) request and waits for a one-cycle resp pulse. The arbiter latches the winner's command, drives it to physical memory until `pmem_resp`, and routes the response back. Simultaneous requests are resolved round-robin. It sits between the two cache controllers and the cacheline adaptor.

## Interface
- `ADDR_W`, default 32: line address width.
- `LINE_W`, default 256: cacheline width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_pmem_read`  in  1  I-cache line-fill request (level, held until `i_pmem_resp`).
- `i_pmem_address`  in  ADDR_W  I-cache line address.
- `i_pmem_rdata`  out  LINE_W  fill data to I-cache.
- `i_pmem_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_pmem_read`  in  1  D-cache fill request (level).
- `d_pmem_write`  in  1  D-cache writeback request (level).
- `d_pmem_address`  in  ADDR_W  D-cache line address.
- `d_pmem_wdata`  in  LINE_W  writeback line.
- `d_pmem_rdata`  out  LINE_W  fill data to D-cache.
- `d_pmem_resp`  out  1  one-cycle completion pulse to D-cache.
- `pmem_read`, `pmem_write`  out  1  command to physical memory.
- `pmem_address`  out  ADDR_W  latched address.
- `pmem_wdata`  out  LINE_W  latched writeback line.
- `pmem_rdata`  in  LINE_W  line from memory.
- `pmem_resp`  in  1  memory completion pulse.
- `busy`  out  1  high in any state other than IDLE.
- `protocol_err`  out  1  sticky; set when `d_pmem_read` and `d_pmem_write` are seen together at grant.

## Operation
- States:
  - IDLE: sample requests.
  - SERVE_I: drive the latched I command.
  - SERVE_D: drive the latched D command.
  - TURN: one dead cycle so the served requester drops its level.
- Arbitration in IDLE:
  - I-request only → SERVE_I.
  - D-request only (read or write) → SERVE_D.
  - Both pending → grant the side opposite to `last_grant`.
  - `last_grant` is updated on every grant.
  - `last_grant` resets to D, so the first tie goes to I.
- On every IDLE→SERVE_x transition, latch `cmd_addr`, `cmd_wdata` and `cmd_write`.
  - For I, `cmd_write` = 0 and `cmd_wdata` is don't-care (latched 0).
  - For D with read and write both high: write wins, `protocol_err` is set, and it stays set until reset.
- SERVE_x behaviour:
  - `pmem_read` = !`cmd_write`; `pmem_write` = `cmd_write`.
  - `pmem_address` = `cmd_addr`; `pmem_wdata` = `cmd_wdata`.
  - Requester address/data changes during SERVE_x are ignored.
- On `pmem_resp` in SERVE_x:
  - Assert the matching `x_pmem_resp` combinationally in the same cycle.
  - Deassert the memory command next cycle; next state TURN.
- `pmem_resp` in IDLE or TURN is ignored: no requester resp, no state change.
- TURN → IDLE unconditionally. Requests are not sampled in TURN.
- `i_pmem_rdata` and `d_pmem_rdata` mirror `pmem_rdata` continuously. Only the resp pulses qualify the data.
- `pmem_read`/`pmem_write` are 0 in IDLE and TURN; `pmem_address`/`pmem_wdata` show the latched values in all states.

## Timing
- Reset (`rst` = 0, asynchronous):
  - state = IDLE, `last_grant` = D.
  - `cmd_addr`, `cmd_wdata`, `cmd_write` = 0; `protocol_err` = 0.
  - Outputs: `pmem_read`, `pmem_write`, `i_pmem_resp`, `d_pmem_resp`, `busy` = 0; `pmem_address`, `pmem_wdata` = 0.
  - Reset mid-SERVE drops the transaction immediately. The memory command falls the same instant; no resp is generated.
- Deassertion is synchronised by the integrating top. The first active edge evaluates IDLE.
- Latency:
  - Request high in IDLE at edge N → memory command high from edge N+1.
  - `pmem_resp` at cycle M → requester resp in cycle M.
  - State is TURN after edge M+1 and IDLE after edge M+2.
  - Earliest next memory command rises at edge M+3.
- The memory command is held constant for the whole SERVE interval. A `pmem_resp` one cycle after grant is legal.
- Starvation bound: a continuously held request waits at most one full transaction of the other requester.

## Test plan
- I-only fill, address 0x0000_0040, memory responds 5 cycles after `pmem_read`:
  - `pmem_read` rises 1 cycle after request, with `pmem_address` = 0x40.
  - `i_pmem_resp` pulses in the same cycle as `pmem_resp`; `d_pmem_resp` stays 0.
  - `busy` falls 2 cycles later.
- D writeback, address 0x0000_1000, `wdata` = {8{32'hDEAD_BEEF}}; the D-cache changes its address mid-SERVE:
  - `pmem_write` = 1 with the latched 0x1000 and the pattern throughout.
  - `d_pmem_resp` pulses once.
- I and D requested in the same IDLE cycle after reset, both held:
  - I is served first, then D (SERVE_D entered at the 3rd edge after the I resp).
  - A second tie is served D first.
- `d_pmem_read` and `d_pmem_write` asserted together:
  - Write is issued and `protocol_err` = 1.
  - The flag stays 1 through later clean transactions until `rst` = 0.
- Spurious `pmem_resp` in IDLE → no resp pulse and no state change. Then `rst` pulled low mid-SERVE_D → `pmem_write`, `busy` and `protocol_err` drop to 0 asynchronously.
